// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes,
// ALU-op classes, datapath select encodings, FSM states and the
// control-word bundle driven by the main controller.
package mips_pkg;

   // Opcode field values (instruction bits [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operation class consumed by the ALU decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   // ALU B operand select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Next-PC select
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Controller states; the encoding is visible on state_o for debug,
   // so the values are pinned explicitly (12 is unused).
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      IMMEX   = 4'd9,
      IMMWB   = 4'd10,
      JUMP    = 4'd11,
      TRAP    = 4'd13
   } state_t;

   // Complete set of datapath controls produced in one cycle
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       imm_zext;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       branch_ne;
      logic [1:0] aluop;
      logic       illegal;
   } ctrl_t;

endpackage : mips_pkg

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. Sequences each
// instruction through FETCH, DECODE and per-opcode execute / memory /
// writeback states. Outputs are Moore-decoded from the state, except
// the FETCH load enables which follow mem_ready, and every write
// enable is forced low while reset_n is asserted.
module multicycle_ctrl
   import mips_pkg::*;
#(
   parameter bit EN_BNE          = 1'b1,
   parameter bit EN_ORI          = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       imm_zext,
   output logic [1:0] pcsrc,
   output logic       pcwrite,
   output logic       branch,
   output logic       branch_ne,
   output logic [1:0] aluop,
   output logic       illegal,
   output logic [3:0] state_o
);

   // Where an unrecognised (or disabled) opcode goes after DECODE
   localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctl_s;     // control word decoded from the current state
   ctrl_t  ctl_out_s; // control word after reset gating

   logic is_beq_s;
   logic is_bne_s;
   logic is_ori_s;

   // Opcode qualifiers, with the optional instructions folded in
   always_comb begin
      is_beq_s = (op == OP_BEQ);
      is_bne_s = EN_BNE && (op == OP_BNE);
      is_ori_s = EN_ORI && (op == OP_ORI);
   end

   // State register; reset drops straight back to FETCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection and Moore output decode
   always_comb begin
      ctl_s   = '0;
      state_d = state_q;
      case (state_q)
         FETCH: begin
            ctl_s.iord    = 1'b0;
            ctl_s.alusrca = 1'b0;
            ctl_s.alusrcb = SRCB_FOUR;
            ctl_s.aluop   = ALU_ADD;
            ctl_s.pcsrc   = PC_ALU;
            // IR load and PC+4 only once the instruction word is back
            ctl_s.irwrite = mem_ready;
            ctl_s.pcwrite = mem_ready;
            if (mem_ready) begin
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            // Precompute the branch target while the register file is read
            ctl_s.alusrca = 1'b0;
            ctl_s.alusrcb = SRCB_IMMSH2;
            ctl_s.aluop   = ALU_ADD;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_BNE:       state_d = EN_BNE ? BRANCH : ILLEGAL_NEXT;
               OP_ADDI:      state_d = IMMEX;
               OP_ORI:       state_d = EN_ORI ? IMMEX : ILLEGAL_NEXT;
               OP_J:         state_d = JUMP;
               default:      state_d = ILLEGAL_NEXT;
            endcase
         end
         MEMADR: begin
            ctl_s.alusrca = 1'b1;
            ctl_s.alusrcb = SRCB_IMM;
            ctl_s.aluop   = ALU_ADD;
            case (op)
               OP_LW:   state_d = MEMRD;
               OP_SW:   state_d = MEMWR;
               default: state_d = FETCH;
            endcase
         end
         MEMRD: begin
            ctl_s.iord = 1'b1;
            if (mem_ready) begin
               state_d = MEMWB;
            end else begin
               state_d = MEMRD;
            end
         end
         MEMWB: begin
            ctl_s.regdst   = 1'b0;
            ctl_s.memtoreg = 1'b1;
            ctl_s.regwrite = 1'b1;
            state_d        = FETCH;
         end
         MEMWR: begin
            // Strobe is held for the whole access, including the ready cycle
            ctl_s.iord     = 1'b1;
            ctl_s.memwrite = 1'b1;
            if (mem_ready) begin
               state_d = FETCH;
            end else begin
               state_d = MEMWR;
            end
         end
         EXECUTE: begin
            ctl_s.alusrca = 1'b1;
            ctl_s.alusrcb = SRCB_REG;
            ctl_s.aluop   = ALU_FUNCT;
            state_d       = ALUWB;
         end
         ALUWB: begin
            ctl_s.regdst   = 1'b1;
            ctl_s.memtoreg = 1'b0;
            ctl_s.regwrite = 1'b1;
            state_d        = FETCH;
         end
         BRANCH: begin
            ctl_s.alusrca   = 1'b1;
            ctl_s.alusrcb   = SRCB_REG;
            ctl_s.aluop     = ALU_SUB;
            ctl_s.pcsrc     = PC_ALUOUT;
            // Opcodes are mutually exclusive, so at most one condition fires
            ctl_s.branch    = is_beq_s;
            ctl_s.branch_ne = is_bne_s;
            state_d         = FETCH;
         end
         IMMEX: begin
            ctl_s.alusrca = 1'b1;
            ctl_s.alusrcb = SRCB_IMM;
            if (is_ori_s) begin
               ctl_s.aluop    = ALU_OR;
               ctl_s.imm_zext = 1'b1;
            end else begin
               ctl_s.aluop    = ALU_ADD;
               ctl_s.imm_zext = 1'b0;
            end
            state_d = IMMWB;
         end
         IMMWB: begin
            ctl_s.regdst   = 1'b0;
            ctl_s.memtoreg = 1'b0;
            ctl_s.regwrite = 1'b1;
            state_d        = FETCH;
         end
         JUMP: begin
            ctl_s.pcsrc   = PC_JUMP;
            ctl_s.pcwrite = 1'b1;
            state_d       = FETCH;
         end
         TRAP: begin
            // Sticky until reset; every enable stays low
            ctl_s.illegal = 1'b1;
            state_d       = TRAP;
         end
         default: begin
            // Unused encoding: recover by refetching
            state_d = FETCH;
         end
      endcase
   end

   // Kill all write enables while reset is held so nothing partial commits
   always_comb begin
      ctl_out_s = ctl_s;
      if (!reset_n) begin
         ctl_out_s.memwrite  = 1'b0;
         ctl_out_s.irwrite   = 1'b0;
         ctl_out_s.regwrite  = 1'b0;
         ctl_out_s.pcwrite   = 1'b0;
         ctl_out_s.branch    = 1'b0;
         ctl_out_s.branch_ne = 1'b0;
      end else begin
         ctl_out_s = ctl_s;
      end
   end

   assign iord      = ctl_out_s.iord;
   assign memwrite  = ctl_out_s.memwrite;
   assign irwrite   = ctl_out_s.irwrite;
   assign regdst    = ctl_out_s.regdst;
   assign memtoreg  = ctl_out_s.memtoreg;
   assign regwrite  = ctl_out_s.regwrite;
   assign alusrca   = ctl_out_s.alusrca;
   assign alusrcb   = ctl_out_s.alusrcb;
   assign imm_zext  = ctl_out_s.imm_zext;
   assign pcsrc     = ctl_out_s.pcsrc;
   assign pcwrite   = ctl_out_s.pcwrite;
   assign branch    = ctl_out_s.branch;
   assign branch_ne = ctl_out_s.branch_ne;
   assign aluop     = ctl_out_s.aluop;
   assign illegal   = ctl_out_s.illegal;
   assign state_o   = state_q;

endmodule : multicycle_ctrl

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Three instances share stimulus:
// dut_a (all features, trap on illegal), dut_b (BNE disabled, trap on
// illegal) and dut_c (ORI disabled, illegal returns to FETCH).
module tb_multicycle_ctrl;
   import mips_pkg::*;

   // Control word bit order:
   // iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb[2]
   // imm_zext pcsrc[2] pcwrite branch branch_ne aluop[2] illegal
   localparam logic [17:0] C_FETCH_RDY  = 18'b0_0_1_0_0_0_0_01_0_00_1_0_0_00_0;
   localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_0_0_0_0_01_0_00_0_0_0_00_0;
   localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_11_0_00_0_0_0_00_0;
   localparam logic [17:0] C_MEMADR     = 18'b0_0_0_0_0_0_1_10_0_00_0_0_0_00_0;
   localparam logic [17:0] C_MEMRD      = 18'b1_0_0_0_0_0_0_00_0_00_0_0_0_00_0;
   localparam logic [17:0] C_MEMWB      = 18'b0_0_0_0_1_1_0_00_0_00_0_0_0_00_0;
   localparam logic [17:0] C_MEMWR      = 18'b1_1_0_0_0_0_0_00_0_00_0_0_0_00_0;
   localparam logic [17:0] C_EXEC       = 18'b0_0_0_0_0_0_1_00_0_00_0_0_0_10_0;
   localparam logic [17:0] C_ALUWB      = 18'b0_0_0_1_0_1_0_00_0_00_0_0_0_00_0;
   localparam logic [17:0] C_BEQ        = 18'b0_0_0_0_0_0_1_00_0_01_0_1_0_01_0;
   localparam logic [17:0] C_BNE        = 18'b0_0_0_0_0_0_1_00_0_01_0_0_1_01_0;
   localparam logic [17:0] C_ADDI       = 18'b0_0_0_0_0_0_1_10_0_00_0_0_0_00_0;
   localparam logic [17:0] C_ORI        = 18'b0_0_0_0_0_0_1_10_1_00_0_0_0_11_0;
   localparam logic [17:0] C_IMMWB      = 18'b0_0_0_0_0_1_0_00_0_00_0_0_0_00_0;
   localparam logic [17:0] C_JUMP       = 18'b0_0_0_0_0_0_0_00_0_10_1_0_0_00_0;
   localparam logic [17:0] C_TRAP       = 18'b0_0_0_0_0_0_0_00_0_00_0_0_0_00_1;

   logic       clk;
   logic       reset_n;
   logic [5:0] op;
   logic       mem_ready;

   wire [17:0] ctl_a, ctl_b, ctl_c;
   wire [3:0]  st_a, st_b, st_c;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_ctrl dut_a (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .iord(ctl_a[17]), .memwrite(ctl_a[16]), .irwrite(ctl_a[15]),
      .regdst(ctl_a[14]), .memtoreg(ctl_a[13]), .regwrite(ctl_a[12]),
      .alusrca(ctl_a[11]), .alusrcb(ctl_a[10:9]), .imm_zext(ctl_a[8]),
      .pcsrc(ctl_a[7:6]), .pcwrite(ctl_a[5]), .branch(ctl_a[4]),
      .branch_ne(ctl_a[3]), .aluop(ctl_a[2:1]), .illegal(ctl_a[0]),
      .state_o(st_a)
   );

   multicycle_ctrl #(.EN_BNE(1'b0), .EN_ORI(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .iord(ctl_b[17]), .memwrite(ctl_b[16]), .irwrite(ctl_b[15]),
      .regdst(ctl_b[14]), .memtoreg(ctl_b[13]), .regwrite(ctl_b[12]),
      .alusrca(ctl_b[11]), .alusrcb(ctl_b[10:9]), .imm_zext(ctl_b[8]),
      .pcsrc(ctl_b[7:6]), .pcwrite(ctl_b[5]), .branch(ctl_b[4]),
      .branch_ne(ctl_b[3]), .aluop(ctl_b[2:1]), .illegal(ctl_b[0]),
      .state_o(st_b)
   );

   multicycle_ctrl #(.EN_BNE(1'b1), .EN_ORI(1'b0), .TRAP_ON_ILLEGAL(1'b0)) dut_c (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .iord(ctl_c[17]), .memwrite(ctl_c[16]), .irwrite(ctl_c[15]),
      .regdst(ctl_c[14]), .memtoreg(ctl_c[13]), .regwrite(ctl_c[12]),
      .alusrca(ctl_c[11]), .alusrcb(ctl_c[10:9]), .imm_zext(ctl_c[8]),
      .pcsrc(ctl_c[7:6]), .pcwrite(ctl_c[5]), .branch(ctl_c[4]),
      .branch_ne(ctl_c[3]), .aluop(ctl_c[2:1]), .illegal(ctl_c[0]),
      .state_o(st_c)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive mem_ready, then check dut_a at the falling edge
   task automatic step_only(input string tag, input logic rdy, input logic [3:0] es, input logic [17:0] ec);
      mem_ready = rdy;
      @(negedge clk);
      check_val({tag, " state"}, 32'(st_a), 32'(es));
      check_val({tag, " ctl"}, 32'(ctl_a), 32'(ec));
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic rdy, input logic [3:0] es, input logic [17:0] ec);
      step_only(tag, rdy, es, ec);
      adv();
   endtask

   // Pulse reset between edges; state and enables must drop immediately
   task automatic reset_pulse(input string tag);
      reset_n = 1'b0;
      #1;
      check_val({tag, " state"}, 32'(st_a), 32'(FETCH));
      check_val({tag, " ctl"}, 32'(ctl_a), 32'(C_FETCH_WAIT));
      adv();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      mem_ready = 1'b1;
      op        = OP_RTYPE;
      repeat (2) @(posedge clk);
      #1;
      // In reset with mem_ready high: FETCH, load enables gated off
      check_val("reset state", 32'(st_a), 32'(FETCH));
      check_val("reset ctl", 32'(ctl_a), 32'(C_FETCH_WAIT));
      check_val("reset ctl b", 32'(ctl_b), 32'(C_FETCH_WAIT));
      reset_n = 1'b1;

      // R-type: 4 cycles, writeback in cycle 4 only
      op = OP_RTYPE;
      step("rt c1", 1'b1, FETCH, C_FETCH_RDY);
      step("rt c2", 1'b1, DECODE, C_DECODE);
      step("rt c3", 1'b1, EXECUTE, C_EXEC);
      step("rt c4", 1'b1, ALUWB, C_ALUWB);

      // LW with two wait cycles in MEMRD: 7 cycles total
      op = OP_LW;
      step("lw c1", 1'b1, FETCH, C_FETCH_RDY);
      step("lw c2", 1'b1, DECODE, C_DECODE);
      step("lw c3", 1'b1, MEMADR, C_MEMADR);
      step("lw c4", 1'b0, MEMRD, C_MEMRD);
      step("lw c5", 1'b0, MEMRD, C_MEMRD);
      step("lw c6", 1'b1, MEMRD, C_MEMRD);
      step("lw c7", 1'b1, MEMWB, C_MEMWB);

      // SW with one fetch wait and one write wait
      op = OP_SW;
      step("sw c1", 1'b0, FETCH, C_FETCH_WAIT);
      step("sw c2", 1'b1, FETCH, C_FETCH_RDY);
      step("sw c3", 1'b1, DECODE, C_DECODE);
      step("sw c4", 1'b1, MEMADR, C_MEMADR);
      step("sw c5", 1'b0, MEMWR, C_MEMWR);
      step("sw c6", 1'b1, MEMWR, C_MEMWR);

      // BEQ: 3 cycles
      op = OP_BEQ;
      step("beq c1", 1'b1, FETCH, C_FETCH_RDY);
      step("beq c2", 1'b1, DECODE, C_DECODE);
      step("beq c3", 1'b1, BRANCH, C_BEQ);

      // BNE: decoded by dut_a, trapped by dut_b
      op = OP_BNE;
      step("bne c1", 1'b1, FETCH, C_FETCH_RDY);
      step_only("bne c2", 1'b1, DECODE, C_DECODE);
      check_val("bne c2 b state", 32'(st_b), 32'(DECODE));
      adv();
      step_only("bne c3", 1'b1, BRANCH, C_BNE);
      check_val("bne c3 b state", 32'(st_b), 32'(TRAP));
      check_val("bne c3 b ctl", 32'(ctl_b), 32'(C_TRAP));
      adv();
      for (int i = 0; i < 10; i++) begin
         mem_ready = i[0];
         @(negedge clk);
         check_val("bne trap hold b state", 32'(st_b), 32'(TRAP));
         check_val("bne trap hold b ctl", 32'(ctl_b), 32'(C_TRAP));
         adv();
      end
      reset_pulse("rst after bne");
      check_val("b after reset", 32'(st_b), 32'(FETCH));

      // ADDI: 4 cycles, sign-extended add
      op = OP_ADDI;
      step("addi c1", 1'b1, FETCH, C_FETCH_RDY);
      step("addi c2", 1'b1, DECODE, C_DECODE);
      step("addi c3", 1'b1, IMMEX, C_ADDI);
      step("addi c4", 1'b1, IMMWB, C_IMMWB);

      // ORI: OR class with zero-extension; dut_c treats it as a NOP
      op = OP_ORI;
      step("ori c1", 1'b1, FETCH, C_FETCH_RDY);
      step("ori c2", 1'b1, DECODE, C_DECODE);
      step_only("ori c3", 1'b1, IMMEX, C_ORI);
      check_val("ori c3 c state", 32'(st_c), 32'(FETCH));
      adv();
      step("ori c4", 1'b1, IMMWB, C_IMMWB);

      // J: 3 cycles
      op = OP_J;
      step("j c1", 1'b1, FETCH, C_FETCH_RDY);
      step("j c2", 1'b1, DECODE, C_DECODE);
      step("j c3", 1'b1, JUMP, C_JUMP);
      step("j c4", 1'b1, FETCH, C_FETCH_RDY);

      // Undefined opcode traps in dut_a and stays there
      reset_pulse("rst before ill");
      op = 6'b111111;
      step("ill c1", 1'b1, FETCH, C_FETCH_RDY);
      step_only("ill c2", 1'b1, DECODE, C_DECODE);
      check_val("ill c2 c state", 32'(st_c), 32'(DECODE));
      adv();
      step_only("ill c3", 1'b0, TRAP, C_TRAP);
      check_val("ill c3 c state", 32'(st_c), 32'(FETCH));
      adv();
      step("ill c4", 1'b1, TRAP, C_TRAP);
      step("ill c5", 1'b0, TRAP, C_TRAP);
      reset_pulse("rst exit trap");

      // SW interrupted by reset while waiting on memory
      op = OP_SW;
      step("swr c1", 1'b1, FETCH, C_FETCH_RDY);
      step("swr c2", 1'b1, DECODE, C_DECODE);
      step("swr c3", 1'b1, MEMADR, C_MEMADR);
      step_only("swr c4", 1'b0, MEMWR, C_MEMWR);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("swr rst memwrite", 32'(ctl_a[16]), 32'd0);
      check_val("swr rst state", 32'(st_a), 32'(FETCH));
      check_val("swr rst ctl", 32'(ctl_a), 32'(C_FETCH_WAIT));
      adv();
      reset_n = 1'b1;
      step("swr refetch", 1'b1, FETCH, C_FETCH_RDY);
      step("swr redecode", 1'b1, DECODE, C_DECODE);
      step("swr readr", 1'b1, MEMADR, C_MEMADR);
      step("swr write", 1'b1, MEMWR, C_MEMWR);
      step("swr done", 1'b1, FETCH, C_FETCH_RDY);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_multicycle_ctrl

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath; successor to the single-cycle main decoder.
- Sequences each instruction over 3-5+ states: FETCH, DECODE, then per-opcode execute, memory and writeback states.
- Drives the datapath mux selects, write enables and the ALU-op class; the existing ALU decoder consumes aluop.
- Adds a memory ready handshake (variable-latency memory), optional BNE/ORI, and an illegal-opcode trap.

Parameters:
EN_BNE, 1, 1 = opcode 000101 (BNE) is decoded; 0 = BNE is illegal
EN_ORI, 1, 1 = opcode 001101 (ORI) is decoded; 0 = ORI is illegal
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP and stays there; 0 = illegal opcode returns to FETCH as a NOP

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
op  in  6  opcode field from the instruction register
mem_ready  in  1  memory has completed the current access this cycle
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load enable
regdst  out  1  register write address select: 1 = rd, 0 = rt
memtoreg  out  1  register write data select: 1 = memory data, 0 = ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = immediate, 11 = immediate shifted left 2
imm_zext  out  1  immediate is zero-extended (ORI) instead of sign-extended
pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcwrite  out  1  unconditional PC write
branch  out  1  BEQ condition enable
branch_ne  out  1  BNE condition enable
aluop  out  2  ALU operation class: 00 = add, 01 = sub, 10 = use funct, 11 = or
illegal  out  1  high while the FSM is in TRAP
state_o  out  4  current state encoding, for debug

Behaviour:
- State register uses the asynchronous active-low reset: reset_n low forces FETCH immediately.
- While reset_n is low, memwrite, irwrite, regwrite, pcwrite, branch and branch_ne are gated to 0 combinationally.
- Outputs are decoded from the state (Moore). The only exceptions are the mem_ready-gated enables listed below.
- Every output not listed for a state is 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Next state by op: LW/SW -> MEMADR, R-type -> EXECUTE, BEQ/BNE -> BRANCH, ADDI/ORI -> IMMEX, J -> JUMP.
  - Any other op, or a disabled BNE/ORI -> TRAP if TRAP_ON_ILLEGAL=1, else FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR:
  - iord=1, memwrite=1.
  - memwrite stays high for every wait cycle.
  - Goes to FETCH on the cycle mem_ready=1 (memwrite is high in that cycle too).
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - branch=1 for BEQ, branch_ne=1 for BNE; the two are never both high.
  - Goes to FETCH.
- IMMEX:
  - alusrca=1, alusrcb=10.
  - ADDI: aluop=00, imm_zext=0. ORI: aluop=11, imm_zext=1.
  - Goes to IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1. Goes to FETCH.
- TRAP: illegal=1 and all enables 0. Exited only by reset.
- op is sampled from the instruction register, which is stable after FETCH. op is used in DECODE, MEMADR, BRANCH and IMMEX.
- Cycle counts with mem_ready tied to 1:
  - R-type, ADDI, ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Each 0-cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction: enables drop in the same cycle with no partial writeback; execution resumes at FETCH after reset_n rises.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J;
  - aluop constants: ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR;
  - the 4-bit enum state_t (FETCH=0 ... TRAP=13) used for state_o.
- Single module: next-state logic and output decode in one block. No sub-module is needed.

Test Plan:
- R-type, mem_ready=1 -> states FETCH, DECODE, EXECUTE, ALUWB; regwrite=1, regdst=1 only in cycle 4; back in FETCH at cycle 5.
- LW, mem_ready held 0 for 2 cycles in MEMRD -> total 7 cycles; memtoreg=1, regwrite=1 in MEMWB only; iord=1 in all 3 MEMRD cycles.
- BNE (op=000101), EN_BNE=1 -> branch_ne=1, branch=0, pcsrc=01, aluop=01 in cycle 3.
- BNE with EN_BNE=0, TRAP_ON_ILLEGAL=1 -> TRAP entered after DECODE; illegal=1 and all enables 0 for 10+ cycles.
- ORI -> IMMEX shows aluop=11, imm_zext=1; IMMWB shows regwrite=1, regdst=0.
- SW with reset_n pulsed low during MEMWR wait -> memwrite drops to 0 asynchronously; state_o=0 (FETCH); the next fetch completes normally.
